// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_HOST,
        OWN_DATA,
        OWN_INSTR
    } owner_t;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; promote lifts fetch above data.
module starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic promote
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count;

    // NOTE: non-blocking assignments in clocked logic so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!i_req || i_gnt) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // A limit of zero keeps count pinned at zero, so promotion never fires.
    assign promote = (STARVE_LIMIT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates host, data and fetch ports onto one single-port synchronous RAM.
// Fixed priority H > D > I, with fetch promoted above data once it has starved.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          h_req,
    input  logic [AW-1:0] h_addr,
    input  logic [1:0]    h_we,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,

    output logic [DW-1:0] rdata,

    output logic [AW-1:0] m_addr,
    output logic          m_oe,
    output logic [1:0]    m_we,
    output logic [DW-1:0] m_dout,
    input  logic [DW-1:0] m_din
);

    owner_t winner;
    owner_t tag;
    logic   promote;

    starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_gnt   (i_gnt),
        .promote (promote)
    );

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        winner = OWN_NONE;
        if (!rst) begin
            if (h_req)                winner = OWN_HOST;
            else if (i_req && promote) winner = OWN_INSTR;
            else if (d_req)           winner = OWN_DATA;
            else if (i_req)           winner = OWN_INSTR;
        end
    end

    always_comb begin
        m_addr = '0;
        m_we   = WE_NONE;
        m_dout = '0;
        case (winner)
            OWN_HOST: begin
                m_addr = h_addr;
                m_we   = h_we;
                m_dout = h_wdata;
            end
            OWN_DATA: begin
                m_addr = d_addr;
                m_we   = d_we;
                m_dout = d_wdata;
            end
            OWN_INSTR: begin
                m_addr = i_addr;
            end
            default: ;
        endcase
    end

    assign m_oe  = (winner != OWN_NONE) && (m_we == WE_NONE);
    assign h_gnt = (winner == OWN_HOST);
    assign d_gnt = (winner == OWN_DATA);
    assign i_gnt = (winner == OWN_INSTR);

    // Only read grants are tagged; writes return nothing.
    always_ff @(posedge clk) begin
        if (rst) tag <= OWN_NONE;
        else     tag <= m_oe ? winner : OWN_NONE;
    end

    // Gating with rst drops a read that was granted just before reset asserted.
    assign h_rvalid = !rst && (tag == OWN_HOST);
    assign d_rvalid = !rst && (tag == OWN_DATA);
    assign i_rvalid = !rst && (tag == OWN_INSTR);
    assign rdata    = m_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        owner_t          own;
        logic [DW-1:0]   data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_req, d_req, i_req;
    logic [AW-1:0] h_addr, d_addr, i_addr;
    logic [1:0]    h_we, d_we;
    logic [DW-1:0] h_wdata, d_wdata;
    logic          h_gnt, d_gnt, i_gnt;
    logic          h_rvalid, d_rvalid, i_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] m_addr;
    logic          m_oe;
    logic [1:0]    m_we;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;

    logic [DW-1:0] ram     [0:511];
    logic [DW-1:0] ref_mem [0:511];
    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    string         phase = "reset";

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .h_req    (h_req),
        .h_addr   (h_addr),
        .h_we     (h_we),
        .h_wdata  (h_wdata),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .rdata    (rdata),
        .m_addr   (m_addr),
        .m_oe     (m_oe),
        .m_we     (m_we),
        .m_dout   (m_dout),
        .m_din    (m_din)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data appears one cycle after m_oe.
    always @(posedge clk) begin
        if (m_we[0]) ram[m_addr[8:0]][7:0]  <= m_dout[7:0];
        if (m_we[1]) ram[m_addr[8:0]][15:8] <= m_dout[15:8];
        if (m_oe)    m_din <= ram[m_addr[8:0]];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h, expected %h", phase, tag, act, exp);
        end
    endtask

    function automatic logic [2:0] sel(input owner_t o);
        case (o)
            OWN_HOST:  return 3'b100;
            OWN_DATA:  return 3'b010;
            OWN_INSTR: return 3'b001;
            default:   return 3'b000;
        endcase
    endfunction

    // Checks this cycle's return and grant against expectations, then advances one clock.
    task automatic step(input owner_t exp_win);
        exp_t          e;
        logic [AW-1:0] a;
        logic [1:0]    we;
        logic [DW-1:0] wd;
        #1;
        e.own  = OWN_NONE;
        e.data = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        if (rst) e.own = OWN_NONE;
        check("rvalid", 32'(sel(e.own)), 32'({h_rvalid, d_rvalid, i_rvalid}));
        if (e.own != OWN_NONE) check("rdata", 32'(rdata), 32'(e.data));
        check("gnt", 32'({h_gnt, d_gnt, i_gnt}), 32'(sel(exp_win)));

        case (exp_win)
            OWN_HOST:  begin a = h_addr; we = h_we; wd = h_wdata; end
            OWN_DATA:  begin a = d_addr; we = d_we; wd = d_wdata; end
            OWN_INSTR: begin a = i_addr; we = 2'b00; wd = '0; end
            default:   begin a = '0; we = 2'b00; wd = '0; end
        endcase
        check("m_addr", 32'(m_addr), 32'(a));
        check("m_we", 32'(m_we), 32'(we));
        check("m_oe", 32'(m_oe), 32'((exp_win != OWN_NONE) && (we == 2'b00)));
        if (we != 2'b00 || exp_win == OWN_NONE) check("m_dout", 32'(m_dout), 32'(wd));

        if (exp_win != OWN_NONE) begin
            if (we == 2'b00) begin
                e.own  = exp_win;
                e.data = ref_mem[a[8:0]];
                sb_q.push_back(e);
            end else begin
                if (we[0]) ref_mem[a[8:0]][7:0]  = wd[7:0];
                if (we[1]) ref_mem[a[8:0]][15:8] = wd[15:8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 512; k++) begin
            ram[k]     = '0;
            ref_mem[k] = '0;
        end
        ram[16'h0010] = 16'hA5C3;  ref_mem[16'h0010] = 16'hA5C3;
        ram[16'h0020] = 16'h0034;  ref_mem[16'h0020] = 16'h0034;
        ram[16'h0000] = 16'h1111;  ref_mem[16'h0000] = 16'h1111;
        ram[16'h0100] = 16'h2222;  ref_mem[16'h0100] = 16'h2222;

        // Reset with every port requesting: all outputs forced idle.
        rst = 1'b1;
        h_req = 1'b1; h_addr = 16'h0030; h_we = 2'b11; h_wdata = 16'hDEAD;
        d_req = 1'b1; d_addr = 16'h0040; d_we = 2'b01; d_wdata = 16'hBEAD;
        i_req = 1'b1; i_addr = 16'h0050;
        step(OWN_NONE);
        step(OWN_NONE);
        rst = 1'b0; h_req = 1'b0; d_req = 1'b0; i_req = 1'b0;
        step(OWN_NONE);

        phase = "single_i";
        i_req = 1'b1; i_addr = 16'h0010;
        step(OWN_INSTR);
        i_req = 1'b0;
        step(OWN_NONE);

        phase = "d_byte_write";
        d_req = 1'b1; d_we = 2'b10; d_addr = 16'h0020; d_wdata = 16'h1200;
        i_req = 1'b1; i_addr = 16'h0020;
        step(OWN_DATA);
        d_req = 1'b0;
        step(OWN_INSTR);
        i_req = 1'b0;
        step(OWN_NONE);

        phase = "pipelined";
        i_req = 1'b1; i_addr = 16'h0000;
        step(OWN_INSTR);
        i_req = 1'b0; d_req = 1'b1; d_we = 2'b00; d_addr = 16'h0100;
        step(OWN_DATA);
        d_req = 1'b0;
        step(OWN_NONE);

        phase = "starve";
        d_req = 1'b1; i_req = 1'b1;
        for (int k = 0; k < 10; k++) step((k % 5 == 4) ? OWN_INSTR : OWN_DATA);

        phase = "host_dominance";
        i_addr = 16'h0010;
        for (int k = 0; k < 4; k++) step(OWN_DATA);
        h_req = 1'b1; h_we = 2'b11; h_addr = 16'h0010; h_wdata = 16'hBEEF;
        for (int k = 0; k < 5; k++) step(OWN_HOST);
        h_req = 1'b0;
        step(OWN_INSTR);
        i_req = 1'b0;
        step(OWN_DATA);
        d_req = 1'b0;
        step(OWN_NONE);

        phase = "host_read";
        h_req = 1'b1; h_we = 2'b00; h_addr = 16'h0020;
        step(OWN_HOST);
        h_req = 1'b0;
        step(OWN_NONE);

        phase = "reset_mid_read";
        i_req = 1'b1; i_addr = 16'h0000;
        step(OWN_INSTR);
        rst = 1'b1; h_req = 1'b1; d_req = 1'b1;
        step(OWN_NONE);
        step(OWN_NONE);
        rst = 1'b0; h_req = 1'b0; d_req = 1'b0; i_addr = 16'h0010;
        step(OWN_INSTR);
        i_req = 1'b0;
        step(OWN_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
